// File: rtl/instr_encoder.sv
// instr_encoder: assembles MIPS instruction words (R, LW, SW, BEQ, J) from
// field bundles and writes them to sequential instruction-memory addresses.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-low reset
//   start             begin a load session (honoured in IDLE or DONE)
//   in_valid/in_ready field-bundle handshake; in_last marks the final bundle
//   kind, rs, rt, rd, shamt, funct, imm, target   instruction fields
//   mem_we/mem_addr/mem_wdata   one-cycle write strobe with address and word
//   count             words written this session
//   busy              session in progress (RUN)
//   full              memory capacity reached
//   err               sticky flag: an illegal kind was seen this session
module instr_encoder #(
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        kind,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              full,
    output logic              err
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  CAPACITY = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    localparam logic [2:0] KIND_R   = 3'd0;
    localparam logic [2:0] KIND_LW  = 3'd1;
    localparam logic [2:0] KIND_SW  = 3'd2;
    localparam logic [2:0] KIND_BEQ = 3'd3;
    localparam logic [2:0] KIND_J   = 3'd4;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               full_q, full_d;
    logic               err_q, err_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;

    logic [31:0]        enc_word;
    logic               enc_legal;
    logic               hs;
    logic               fills;
    logic [CNT_W-1:0]   count_inc;

    // Field bundle to instruction word; kinds 5..7 are flagged illegal
    always_comb begin
        enc_word  = 32'h0;
        enc_legal = 1'b1;
        case (kind)
            KIND_R:   enc_word = {OP_R, rs, rt, rd, shamt, funct};
            KIND_LW:  enc_word = {OP_LW, rs, rt, imm};
            KIND_SW:  enc_word = {OP_SW, rs, rt, imm};
            KIND_BEQ: enc_word = {OP_BEQ, rs, rt, imm};
            KIND_J:   enc_word = {OP_J, target};
            default:  enc_legal = 1'b0;
        endcase
    end

    // in_ready_q already encodes (state == RUN && !full)
    assign hs        = in_valid & in_ready_q;
    assign count_inc = count_q + CNT_W'(1);
    assign fills     = enc_legal && (count_inc == CAPACITY);

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        count_d     = count_q;
        full_d      = full_q;
        err_d       = err_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    addr_d  = BASE;
                    count_d = '0;
                    err_d   = 1'b0;
                    full_d  = 1'b0;
                end
            end
            RUN: begin
                if (hs) begin
                    if (enc_legal) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = addr_q;
                        mem_wdata_d = enc_word;
                        addr_d      = addr_q + ADDR_W'(1);
                        count_d     = count_inc;
                        if (fills) begin
                            full_d = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                    // Illegal bundles are still consumed, so in_last ends the session
                    if (in_last || fills) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == RUN) && !full_d;
        busy_d     = (state_d == RUN);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= BASE;
            count_q     <= '0;
            full_q      <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign full      = full_q;
    assign err       = err_q;
    assign count     = count_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder (ADDR_W=2 so the capacity limit is reachable).
module tb_instr_encoder;

    localparam int unsigned AW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic [2:0]    kind;
    logic [4:0]    rs, rt, rd, shamt;
    logic [5:0]    funct;
    logic [15:0]   imm;
    logic [25:0]   target;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [AW:0]   count;
    logic          busy, full, err;

    instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .kind(kind), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm(imm), .target(target),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .busy(busy), .full(full), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  kind;
        logic [4:0]  rs, rt, rd, shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] target;
        logic [31:0] word;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   word;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[7];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   prev_wr  = -10;
    int   last_wr  = -10;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            prev_wr = last_wr;
            last_wr = cyc;
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr=%0d data=0x%0h with no write expected", mem_addr, mem_wdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e.addr));
                check("wr_data", mem_wdata, e.word);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present a bundle until accepted or the wait bound expires
    task automatic send(input vec_t v, input logic last, input logic legal,
                        input logic [AW-1:0] exp_addr, output bit accepted);
        kind = v.kind; rs = v.rs; rt = v.rt; rd = v.rd; shamt = v.shamt;
        funct = v.funct; imm = v.imm; target = v.target;
        in_last  = last;
        in_valid = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 6 && !accepted; i++) begin
            if (in_ready === 1'b1) begin
                accepted = 1'b1;
                if (legal) sb.push_back('{addr: exp_addr, word: v.word});
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    vec_t bad;
    bit   acc;

    initial begin
        //            kind  rs  rt  rd  sh  funct  imm       target       word
        vecs[0] = '{3'd0,  1,  2,  3,  0, 6'h20, 16'h0000, 26'h0,       32'h00221820};
        vecs[1] = '{3'd1,  9,  8,  0,  0, 6'h00, 16'h0004, 26'h0,       32'h8D280004};
        vecs[2] = '{3'd2,  9,  8,  0,  0, 6'h00, 16'h0004, 26'h0,       32'hAD280004};
        vecs[3] = '{3'd3,  1,  2,  0,  0, 6'h00, 16'hFFFF, 26'h0,       32'h1022FFFF};
        vecs[4] = '{3'd4,  0,  0,  0,  0, 6'h00, 16'h0000, 26'h0100000, 32'h08100000};
        vecs[5] = '{3'd0, 31, 31, 31, 31, 6'h3F, 16'h0000, 26'h0,       32'h03FFFFFF};
        vecs[6] = '{3'd4,  0,  0,  0,  0, 6'h00, 16'h0000, 26'h3FFFFFF, 32'h0BFFFFFF};
        bad     = '{3'd5,  7,  7,  7,  7, 6'h01, 16'h1234, 26'h0,       32'h0};

        rst = 1'b0; start = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        kind = '0; rs = '0; rt = '0; rd = '0; shamt = '0; funct = '0; imm = '0; target = '0;
        repeat (3) @(negedge clk);

        // Reset state (start held high during reset must be overridden)
        check("rst_mem_we",   32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_wdata",    mem_wdata, 0);
        check("rst_count",    32'(count), 0);
        check("rst_full",     32'(full), 0);
        check("rst_err",      32'(err), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_busy",     32'(busy), 0);
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);

        // Table: one-word sessions, each closed by in_last
        for (int i = 0; i < 7; i++) begin
            do_start();
            check("tbl_ready", 32'(in_ready), 1);
            send(vecs[i], 1'b1, 1'b1, 0, acc);
            check("tbl_accept", 32'(acc), 1);
            check("tbl_count",  32'(count), 1);
            check("tbl_busy",   32'(busy), 0);
            check("tbl_ready_done", 32'(in_ready), 0);
        end

        // LW then SW back-to-back
        do_start();
        send(vecs[1], 1'b0, 1'b1, 0, acc);
        send(vecs[2], 1'b1, 1'b1, 1, acc);
        @(negedge clk);
        check("b2b_consecutive", 32'(last_wr - prev_wr), 1);
        check("b2b_count", 32'(count), 2);

        // BEQ then J with in_last
        do_start();
        send(vecs[3], 1'b0, 1'b1, 0, acc);
        send(vecs[4], 1'b1, 1'b1, 1, acc);
        check("bj_count",  32'(count), 2);
        check("bj_busy",   32'(busy), 0);
        check("bj_ready",  32'(in_ready), 0);
        check("bj_full",   32'(full), 0);

        // Illegal kind: consumed, no write, sticky err
        do_start();
        send(bad, 1'b0, 1'b0, 0, acc);
        check("ill_accept", 32'(acc), 1);
        check("ill_err",    32'(err), 1);
        check("ill_count",  32'(count), 0);
        check("ill_busy",   32'(busy), 1);
        send(vecs[0], 1'b0, 1'b1, 0, acc);
        check("ill_err_sticky", 32'(err), 1);
        check("ill_count_after", 32'(count), 1);
        send(bad, 1'b1, 1'b0, 0, acc);
        check("ill_last_done", 32'(busy), 0);
        check("ill_last_count", 32'(count), 1);
        do_start();
        check("ill_err_clear", 32'(err), 0);
        check("ill_count_clear", 32'(count), 0);

        // Capacity: four writes fill the memory, the fifth is refused
        for (int i = 0; i < 4; i++) begin
            send(vecs[i], 1'b0, 1'b1, AW'(i), acc);
            check("cap_accept", 32'(acc), 1);
        end
        check("cap_full",  32'(full), 1);
        check("cap_ready", 32'(in_ready), 0);
        check("cap_busy",  32'(busy), 0);
        check("cap_count", 32'(count), 4);
        send(vecs[4], 1'b0, 1'b1, 0, acc);
        check("cap_refused", 32'(acc), 0);
        do_start();
        check("cap_full_clear",  32'(full), 0);
        check("cap_count_clear", 32'(count), 0);
        check("cap_ready_again", 32'(in_ready), 1);

        // Reset wins over a handshake in the same cycle
        kind = vecs[0].kind; rs = vecs[0].rs; rt = vecs[0].rt; rd = vecs[0].rd;
        shamt = vecs[0].shamt; funct = vecs[0].funct;
        in_valid = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        check("rsths_we",    32'(mem_we), 0);
        check("rsths_count", 32'(count), 0);
        check("rsths_busy",  32'(busy), 0);

        // Handshake at edge N, reset at N+1
        do_start();
        send(vecs[5], 1'b0, 1'b1, 0, acc);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("rstn1_we",    32'(mem_we), 0);
        check("rstn1_count", 32'(count), 0);
        check("rstn1_busy",  32'(busy), 0);
        check("rstn1_addr",  32'(mem_addr), 0);
        check("rstn1_wdata", mem_wdata, 0);
        do_start();
        send(vecs[1], 1'b1, 1'b1, 0, acc);
        check("rstn1_rewrite_count", 32'(count), 1);

        @(negedge clk);
        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Writer-side counterpart to the CPU's opcode decoder: turns instruction fields into 32-bit MIPS words and writes them into instruction memory.
- Used by the test/boot path to load programs without hand-assembled hex.
- Supported classes: R-type, LW, SW, BEQ, J. Opcodes are identical to those the control decoder recognises.
- Accepts one field bundle per cycle over a valid/ready handshake and writes to sequential addresses.

Parameters:
ADDR_W, 6, instruction-memory word-address width; capacity 2^ADDR_W words
BASE_ADDR, 0, first word address written after start

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-low (rst=0 resets on the clock edge)
start  input  1  begin a load session (honoured in IDLE or DONE)
in_valid  input  1  field bundle present
in_ready  output  1  encoder accepts the bundle this cycle
in_last  input  1  bundle is the final instruction of the session
kind  input  3  0=R, 1=LW, 2=SW, 3=BEQ, 4=J, 5..7 illegal
rs  input  5  source register
rt  input  5  target register
rd  input  5  destination register (R only)
shamt  input  5  shift amount (R only)
funct  input  6  function code (R only)
imm  input  16  immediate / branch offset (LW, SW, BEQ)
target  input  26  jump target (J)
mem_we  output  1  instruction-memory write strobe
mem_addr  output  ADDR_W  write address
mem_wdata  output  32  encoded instruction
count  output  ADDR_W+1  words written this session
busy  output  1  state is RUN
full  output  1  memory capacity reached
err  output  1  sticky: an illegal kind was received this session

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE.
  - mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, full=0, err=0, in_ready=0.
  - Any write accepted in the previous cycle is discarded: mem_we is 0 after the reset edge.
- States:
  - IDLE: start → RUN; addr=BASE_ADDR, count=0, err=0, full=0.
  - RUN: in_ready=~full. A handshake occurs when in_valid&in_ready.
    - Go to DONE after the handshake if in_last=1, or if the write makes count=2^ADDR_W.
  - DONE: in_ready=0. Outputs hold. start → RUN with the same clears as from IDLE.
- start is ignored while in RUN.
- Encoding:
  - R: {6'b000000, rs, rt, rd, shamt, funct}
  - LW: {6'b100011, rs, rt, imm}
  - SW: {6'b101011, rs, rt, imm}
  - BEQ: {6'b000100, rs, rt, imm}
  - J: {6'b000010, target}
- Latency: handshake at edge N → mem_we=1 with mem_addr/mem_wdata valid for the cycle after edge N, for exactly one cycle.
  - Throughput is one word per cycle; there is no back-pressure from memory.
- Address/count advance by 1 after each legal write.
  - mem_addr wraps modulo 2^ADDR_W only relative to BASE_ADDR arithmetic; it never exceeds capacity because of full.
- Illegal kind (5..7):
  - Bundle is consumed; no write; err=1 (sticky until the next start).
  - Address and count do not advance.
  - If in_last=1 the FSM still goes to DONE.
- full: set when count reaches 2^ADDR_W. in_ready drops in the same cycle. Further in_valid is not consumed.
- Simultaneous in_last with the capacity-filling write: go to DONE once, full=1.
- rst overrides start and the handshake in the same cycle.

Test Plan:
- start, then R rs=1 rt=2 rd=3 shamt=0 funct=0x20 → next cycle: mem_we=1, addr=0, wdata=0x00221820, count=1.
- LW rs=9 rt=8 imm=4, then SW with the same fields back-to-back → 0x8D280004 @addr0, then 0xAD280004 @addr1, on consecutive cycles.
- BEQ rs=1 rt=2 imm=0xFFFF, then J target=0x0100000 with in_last=1 → 0x1022FFFF @0, 0x08100000 @1; state DONE, busy=0, in_ready=0, count=2.
- kind=5 then R (as in the first scenario) → no mem_we for kind=5, err=1; the R word lands at addr 0; err stays 1 until the next start.
- ADDR_W=2, five valid bundles presented → four writes (addr 0..3); full=1 and in_ready=0 after the 4th handshake; the 5th is not consumed; a new start clears full and count.
- Handshake at edge N, rst=0 at edge N+1 → mem_we=0 after N+1, count=0, state IDLE; the subsequent start writes to BASE_ADDR.
